// File: rtl/simon_pkg.sv
// Shared constants, types and helpers for the Simon64/128 datapath.
// Word size, key words, round count, Z3 sequence and rotators.
package simon_pkg;

  localparam int N = 32;
  localparam int M = 4;
  localparam int T = 44;

  localparam logic [N-1:0] C = 32'hFFFF_FFFC;

  // MSB is the first bit of the sequence
  localparam logic [61:0] Z3 =
    62'b11011011_10101100_01100101_11100000_01001000_10100111_00110100_001111;

  localparam logic [5:0] IDX_MAX = 6'(T - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } state_t;

  function automatic logic [N-1:0] ror(
    input logic [N-1:0] x,
    input int unsigned  s
  );
    return (x >> s) | (x << (N - s));
  endfunction

  function automatic logic [N-1:0] rol(
    input logic [N-1:0] x,
    input int unsigned  s
  );
    return (x << s) | (x >> (N - s));
  endfunction

  function automatic logic z3_bit(input logic [5:0] j);
    return Z3[6'd61 - j];
  endfunction

endpackage

// File: rtl/simon64s128_key_step.sv
// One Simon64/128 key-expansion step: k[i] from k[i-1], k[i-3], k[i-4].
// Purely combinational so the encrypt-side scheduler can share it.
module simon64s128_key_step
  import simon_pkg::*;
(
  input  logic [N-1:0] km1,
  input  logic [N-1:0] km3,
  input  logic [N-1:0] km4,
  input  logic         z,
  output logic [N-1:0] ki
);

  logic [N-1:0] t0;
  logic [N-1:0] t1;

  assign t0 = ror(km1, 3) ^ km3;
  assign t1 = t0 ^ ror(t0, 1);
  assign ki = C ^ {{(N-1){1'b0}}, z} ^ km4 ^ t1;

endmodule

// File: rtl/simon64s128_key_sched.sv
// Simon64/128 round-key generator: expands a master key once, then
// replays the stored schedule in either order on request.
module simon64s128_key_sched
  import simon_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] key_in,
  input  logic           key_in_vld,
  output logic           key_in_rdy,
  input  logic           start_vld,
  input  logic           start_dir,
  output logic           start_rdy,
  output logic [N-1:0]   rk,
  output logic [5:0]     rk_idx,
  output logic           rk_last,
  output logic           rk_vld,
  input  logic           rk_rdy,
  output logic           keys_valid
);

  state_t state;
  state_t state_n;

  logic [N-1:0] mem [T];
  logic [5:0]   cnt;
  logic         dir;
  logic [5:0]   nxt;
  logic [5:0]   first;
  logic [N-1:0] k_new;
  logic         key_hs;
  logic         start_hs;
  logic         rk_hs;

  function automatic logic at_end(
    input logic       d,
    input logic [5:0] i
  );
    return d ? (i == 6'd0) : (i == IDX_MAX);
  endfunction

  assign key_in_rdy = (state == IDLE) || (state == READY);
  // a pending key wins over a start request
  assign start_rdy  = (state == READY) && !key_in_vld;

  assign key_hs   = key_in_vld && key_in_rdy;
  assign start_hs = start_vld && start_rdy;
  assign rk_hs    = rk_vld && rk_rdy;

  assign nxt   = dir ? rk_idx - 6'd1 : rk_idx + 6'd1;
  assign first = start_dir ? IDX_MAX : 6'd0;

  simon64s128_key_step u_step (
    .km1 (mem[cnt - 6'd1]),
    .km3 (mem[cnt - 6'd3]),
    .km4 (mem[cnt - 6'd4]),
    .z   (z3_bit(cnt - 6'd4)),
    .ki  (k_new)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (key_hs) state_n = EXPAND;
      EXPAND: if (cnt == IDX_MAX) state_n = READY;
      READY: begin
        if (key_hs)        state_n = EXPAND;
        else if (start_hs) state_n = STREAM;
      end
      STREAM: if (rk_hs && rk_last) state_n = READY;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (key_hs) begin
      for (int j = 0; j < M; j++) mem[j] <= key_in[j*N +: N];
    end else if (state == EXPAND) begin
      mem[cnt] <= k_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 6'd0;
      dir        <= 1'b0;
      keys_valid <= 1'b0;
      rk_vld     <= 1'b0;
      rk_last    <= 1'b0;
      rk         <= '0;
      rk_idx     <= 6'd0;
    end else begin
      if (key_hs) begin
        cnt        <= 6'(M);
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        cnt <= cnt + 6'd1;
        if (cnt == IDX_MAX) keys_valid <= 1'b1;
      end
      if (start_hs) begin
        dir     <= start_dir;
        rk_vld  <= 1'b1;
        rk_idx  <= first;
        rk      <= mem[first];
        rk_last <= at_end(start_dir, first);
      end else if (rk_hs) begin
        if (rk_last) begin
          rk_vld <= 1'b0;
        end else begin
          rk_idx  <= nxt;
          rk      <= mem[nxt];
          rk_last <= at_end(dir, nxt);
        end
      end
    end
  end

endmodule
